cmd_hold_stage: RTL and testbench
=================================

Name: cmd_hold_stage

Overview:
- Input capture stage that sits directly upstream of the priority stage.
- Accepts 2-beat requests from 4 requester ports: beat 0 carries cmd + operand1, beat 1 carries operand2.
- Presents each captured command to the priority stage as a one-cycle nonzero pulse on holdN_prio_req, then holds that port busy until the output stage signals its response is done.
- Supplies operands to ALU1/ALU2, muxed by the request id the priority stage has granted.

Parameters:
- NPORTS, 4, number of requester ports; the id width is fixed at 2.
- DATA_W, 32, operand width.
- CMD_W, 4, command width; 0 means no command.
- TIMEOUT, 255, WAIT-state watchdog limit in cycles (used only with the optional feature).

Ports:
- c_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_cmd_in  in  NPORTS*CMD_W  per-port command; port p uses slice p; nonzero = beat 0.
- req_data_in  in  NPORTS*DATA_W  per-port operand; operand1 on beat 0, operand2 on the following cycle.
- resp_done  in  NPORTS  one-cycle pulse from the output stage: port p's response has been delivered.
- alu1_sel_id  in  2  granted id for ALU1 (the priority stage's alu1 in_req_id).
- alu2_sel_id  in  2  granted id for ALU2.
- hold_prio_req  out  NPORTS*CMD_W  per-port command pulse to the priority stage; port p drives slice p.
- alu1_data1, alu1_data2  out  DATA_W each  operands of port alu1_sel_id.
- alu2_data1, alu2_data2  out  DATA_W each  operands of port alu2_sel_id.
- port_busy  out  NPORTS  port not in IDLE.
- proto_err  out  NPORTS  sticky: a command arrived while the port was not IDLE.

Behaviour:
- Reset: all ports go to IDLE.
  - hold_prio_req = 0, port_busy = 0, proto_err = 0.
  - Operand and command registers = 0, so alu data outputs = 0.
  - Reset asserted mid-operation aborts every port immediately; no pulse is emitted afterwards.
- Per-port FSM, states IDLE, CAP2, ISSUE, WAIT:
  - IDLE: if cmd != 0, latch cmd and operand1, go to CAP2. cmd == 0 means stay.
  - CAP2: latch req_data_in as operand2 unconditionally; go to ISSUE.
  - ISSUE: hold_prio_req slice = latched cmd for exactly this cycle; go to WAIT.
  - WAIT: stay until resp_done[p], then go to IDLE and clear the latched cmd.
- hold_prio_req is registered and is 0 in every state except ISSUE.
- Latency: beat 0 at cycle T, operand2 at T+1, pulse at T+2, WAIT from T+3.
  - Earliest next accept is the cycle after resp_done is sampled.
- Operand registers stay stable from T+2 until the port leaves WAIT.
- resp_done in any state other than WAIT is ignored.
- A nonzero cmd in CAP2, ISSUE or WAIT is dropped and sets proto_err[p]. It clears only on reset.
  - The req_data_in value in CAP2 is always operand2, even if cmd is also nonzero that cycle.
- Simultaneous resp_done and a new cmd on the same port in WAIT: the port goes to IDLE, the cmd is dropped, and proto_err is set.
- Ports are fully independent; all 4 may pulse in the same cycle.
- port_busy[p] = (state != IDLE), driven from the state register.
- ALU operand mux is combinational on alu*_sel_id over the per-port operand registers.
  - Both ALUs may select the same id; both then see identical data.

Optional Feature:
- Macro: CMD_HOLD_TIMEOUT_EN.
- Defined:
  - Each port has an 8-bit WAIT counter, cleared on entry to WAIT.
  - When the counter reaches TIMEOUT without resp_done, the port is forced to IDLE.
  - Adds output timeout_err (NPORTS): a one-cycle pulse on that transition.
  - resp_done on the TIMEOUT cycle wins; no error is raised.
- Undefined: no counter, no timeout_err port; WAIT is unbounded.

Decomposition:
- Package calc_hold_pkg holds:
  - hold_state_t enum {IDLE, CAP2, ISSUE, WAIT}.
  - Constants CMD_W, DATA_W, NPORTS, ID_W=2, CMD_NONE=4'b0.
  - Port id typedef.
- One sub-module, cmd_hold_port: one FSM with its command/operand registers, error flag and optional counter. It is instanced NPORTS times by generate.
- The top level contains only the slicing and the two operand muxes.

Test Plan:
- Single request: port 0 gets cmd=1 with 0x0000_0005 at T, then 0x0000_0003 at T+1.
  - Required: slice 0 of hold_prio_req = 4'h1 at T+2 only.
  - With alu1_sel_id=0: alu1_data1 = 5, alu1_data2 = 3.
  - port_busy[0] stays high until 1 cycle after resp_done[0].
- All 4 ports issue cmds 1, 2, 5, 6 in the same cycle.
  - Required: all 4 pulses at T+2.
  - alu2_sel_id=2 selects port 2's operands.
- Protocol error: port 1 receives cmd=2 while in WAIT.
  - Required: no second pulse; proto_err[1] = 1 until reset; the original operands are unchanged.
- Ignored resp_done: resp_done[3] pulsed in CAP2 and ISSUE is ignored, and the port stays in WAIT.
  - A later resp_done[3] returns the port to IDLE, and a new cmd is accepted the next cycle.
- Reset mid-operation: reset asserted in the ISSUE cycle.
  - Required: hold_prio_req = 0 that edge onward, port_busy = 0, data outputs = 0.
- With CMD_HOLD_TIMEOUT_EN and TIMEOUT=10, send no resp_done.
  - Required: timeout_err pulse 10 cycles after WAIT entry, and the port returns to IDLE.

Source files
------------

// File: rtl/calc_hold_pkg.sv
// Shared types and constants for the command hold stage.
//
// Contents:
//   NPORTS, DATA_W, CMD_W, ID_W  default geometry of the stage
//   CMD_NONE                     command value meaning "no request"
//   hold_state_t                 per-port FSM state
//   port_id_t                    requester id as granted by the priority stage
package calc_hold_pkg;

  localparam int NPORTS = 4;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int ID_W   = 2;

  localparam logic [CMD_W-1:0] CMD_NONE = 4'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAP2  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } hold_state_t;

  typedef logic [ID_W-1:0] port_id_t;

endpackage

// File: rtl/cmd_hold_port.sv
// One requester port of the command hold stage: captures a 2-beat request,
// emits a single-cycle command pulse toward the priority stage, then holds
// the port busy until the output stage reports the response delivered.
//
// Handshake: a nonzero cmd_in in IDLE is beat 0 (cmd + operand1); the very
// next cycle's data_in is operand2, taken unconditionally. There is no
// backpressure; a command arriving while not IDLE is dropped and flagged.
//
// Optional feature (macro CMD_HOLD_TIMEOUT_EN): a WAIT-state watchdog that
// forces the port back to IDLE after TIMEOUT cycles without resp_done and
// pulses timeout_err for one cycle.
//
// Ports:
//   c_clk, reset    clock, synchronous active-high reset
//   cmd_in          command from the requester (nonzero = beat 0)
//   data_in         operand1 on beat 0, operand2 on the next cycle
//   resp_done       response delivered pulse (honoured only in WAIT)
//   hold_prio_req   registered command pulse, nonzero only in ISSUE
//   op1, op2        latched operands
//   state           current FSM state (also used for port_busy)
//   proto_err       sticky: command arrived while not IDLE
//   timeout_err     watchdog pulse (only with CMD_HOLD_TIMEOUT_EN)
module cmd_hold_port
  import calc_hold_pkg::*;
#(
  parameter int DATA_W  = calc_hold_pkg::DATA_W,
  parameter int CMD_W   = calc_hold_pkg::CMD_W
`ifdef CMD_HOLD_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              resp_done,
  output logic [CMD_W-1:0]  hold_prio_req,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output hold_state_t       state,
  output logic              proto_err
`ifdef CMD_HOLD_TIMEOUT_EN
  , output logic            timeout_err
`endif
);

  localparam logic [CMD_W-1:0] NO_CMD = CMD_W'(CMD_NONE);

  logic [CMD_W-1:0] cmd_q;
  logic             cmd_valid;

  assign cmd_valid = (cmd_in != NO_CMD);

`ifdef CMD_HOLD_TIMEOUT_EN
  // Counts cycles already spent in WAIT; the cycle where it equals
  // TIMEOUT-1 is the TIMEOUT-th WAIT cycle, so the forced exit lands the
  // port in IDLE (and timeout_err high) TIMEOUT cycles after WAIT entry.
  logic [7:0] wait_cnt;
`endif

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_q         <= NO_CMD;
      op1           <= '0;
      op2           <= '0;
      hold_prio_req <= '0;
      proto_err     <= 1'b0;
`ifdef CMD_HOLD_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      hold_prio_req <= '0;
`ifdef CMD_HOLD_TIMEOUT_EN
      timeout_err   <= 1'b0;
`endif

      // Any command outside IDLE is dropped; remember that it happened.
      if (cmd_valid && (state != IDLE)) begin
        proto_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q <= cmd_in;
            op1   <= data_in;
            state <= CAP2;
          end
        end
        CAP2: begin
          // Second beat is operand2 regardless of cmd_in this cycle.
          op2           <= data_in;
          hold_prio_req <= cmd_q;
          state         <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
`ifdef CMD_HOLD_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (resp_done) begin
            cmd_q <= NO_CMD;
            state <= IDLE;
          end
`ifdef CMD_HOLD_TIMEOUT_EN
          else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            cmd_q       <= NO_CMD;
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cmd_hold_stage.sv
// Input capture stage in front of the priority stage. Each of NPORTS
// requester ports is handled by an independent cmd_hold_port; this level
// only slices the packed buses and muxes operands for the two ALUs by the
// ids the priority stage has granted.
//
// Optional feature: define CMD_HOLD_TIMEOUT_EN to add the WAIT watchdog
// (TIMEOUT parameter and timeout_err output).
//
// Ports:
//   c_clk, reset      clock, synchronous active-high reset
//   req_cmd_in        per-port command slices (nonzero = beat 0)
//   req_data_in       per-port operand slices
//   resp_done         per-port response-delivered pulse
//   alu1_sel_id       granted id for ALU1
//   alu2_sel_id       granted id for ALU2
//   hold_prio_req     per-port one-cycle command pulse slices
//   alu1_data1/2      operands of port alu1_sel_id
//   alu2_data1/2      operands of port alu2_sel_id
//   port_busy         port not IDLE
//   proto_err         sticky protocol error per port
//   timeout_err       watchdog pulse per port (only with CMD_HOLD_TIMEOUT_EN)
module cmd_hold_stage
  import calc_hold_pkg::*;
#(
  parameter int NPORTS  = calc_hold_pkg::NPORTS,
  parameter int DATA_W  = calc_hold_pkg::DATA_W,
  parameter int CMD_W   = calc_hold_pkg::CMD_W
`ifdef CMD_HOLD_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                     c_clk,
  input  logic                     reset,
  input  logic [NPORTS*CMD_W-1:0]  req_cmd_in,
  input  logic [NPORTS*DATA_W-1:0] req_data_in,
  input  logic [NPORTS-1:0]        resp_done,
  input  port_id_t                 alu1_sel_id,
  input  port_id_t                 alu2_sel_id,
  output logic [NPORTS*CMD_W-1:0]  hold_prio_req,
  output logic [DATA_W-1:0]        alu1_data1,
  output logic [DATA_W-1:0]        alu1_data2,
  output logic [DATA_W-1:0]        alu2_data1,
  output logic [DATA_W-1:0]        alu2_data2,
  output logic [NPORTS-1:0]        port_busy,
  output logic [NPORTS-1:0]        proto_err
`ifdef CMD_HOLD_TIMEOUT_EN
  , output logic [NPORTS-1:0]      timeout_err
`endif
);

  logic [DATA_W-1:0] op1_all   [NPORTS];
  logic [DATA_W-1:0] op2_all   [NPORTS];
  hold_state_t       state_all [NPORTS];

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    cmd_hold_port #(
      .DATA_W (DATA_W),
      .CMD_W  (CMD_W)
`ifdef CMD_HOLD_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT)
`endif
    ) u_port (
      .c_clk         (c_clk),
      .reset         (reset),
      .cmd_in        (req_cmd_in[p*CMD_W +: CMD_W]),
      .data_in       (req_data_in[p*DATA_W +: DATA_W]),
      .resp_done     (resp_done[p]),
      .hold_prio_req (hold_prio_req[p*CMD_W +: CMD_W]),
      .op1           (op1_all[p]),
      .op2           (op2_all[p]),
      .state         (state_all[p]),
      .proto_err     (proto_err[p])
`ifdef CMD_HOLD_TIMEOUT_EN
      , .timeout_err (timeout_err[p])
`endif
    );

    assign port_busy[p] = (state_all[p] != IDLE);
  end

  // Plain combinational muxes; both ALUs may pick the same port.
  assign alu1_data1 = op1_all[alu1_sel_id];
  assign alu1_data2 = op2_all[alu1_sel_id];
  assign alu2_data1 = op1_all[alu2_sel_id];
  assign alu2_data2 = op2_all[alu2_sel_id];

endmodule

// File: tb/tb_cmd_hold_stage.sv
// Self-checking bench for cmd_hold_stage. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_cmd_hold_stage;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int HW = NP * CW;

  logic            c_clk = 1'b0;
  logic            reset;
  logic [HW-1:0]   req_cmd_in;
  logic [NP*DW-1:0] req_data_in;
  logic [NP-1:0]   resp_done;
  logic [1:0]      alu1_sel_id;
  logic [1:0]      alu2_sel_id;
  logic [HW-1:0]   hold_prio_req;
  logic [DW-1:0]   alu1_data1, alu1_data2, alu2_data1, alu2_data2;
  logic [NP-1:0]   port_busy;
  logic [NP-1:0]   proto_err;
`ifdef CMD_HOLD_TIMEOUT_EN
  logic [NP-1:0]   timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  // Expected hold_prio_req vectors, pushed when beat 0 is driven.
  logic [HW-1:0] exp_q[$];
  logic [HW-1:0] exp_v;

  always #5 c_clk = ~c_clk;

  cmd_hold_stage #(
    .NPORTS (NP),
    .DATA_W (DW),
    .CMD_W  (CW)
`ifdef CMD_HOLD_TIMEOUT_EN
    , .TIMEOUT(10)
`endif
  ) dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .req_cmd_in    (req_cmd_in),
    .req_data_in   (req_data_in),
    .resp_done     (resp_done),
    .alu1_sel_id   (alu1_sel_id),
    .alu2_sel_id   (alu2_sel_id),
    .hold_prio_req (hold_prio_req),
    .alu1_data1    (alu1_data1),
    .alu1_data2    (alu1_data2),
    .alu2_data1    (alu2_data1),
    .alu2_data2    (alu2_data2),
    .port_busy     (port_busy),
    .proto_err     (proto_err)
`ifdef CMD_HOLD_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  // ---------------- clock/reset and driver tasks ----------------
  task automatic next_cycle();
    @(posedge c_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge c_clk);
  endtask

  task automatic clear_inputs();
    req_cmd_in  = '0;
    req_data_in = '0;
    resp_done   = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic set_cmd(input int p, input logic [CW-1:0] c);
    req_cmd_in[p*CW +: CW] = c;
  endtask

  task automatic set_data(input int p, input logic [DW-1:0] d);
    req_data_in[p*DW +: DW] = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    alu1_sel_id = 2'd0;
    alu2_sel_id = 2'd3;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    sample();
    checks++;
    if (hold_prio_req !== '0) begin
      errors++; $display("FAIL reset_hold: got %h want 0", hold_prio_req);
    end
    checks++;
    if ({port_busy, proto_err} !== '0) begin
      errors++; $display("FAIL reset_flags: busy=%b err=%b want 0", port_busy, proto_err);
    end
    checks++;
    if ({alu1_data1, alu1_data2, alu2_data1, alu2_data2} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h want 0",
                         alu1_data1, alu1_data2, alu2_data1, alu2_data2);
    end
  endtask

  task automatic test_single();
    next_cycle();                        // cycle T
    set_cmd(0, 4'h1); set_data(0, 32'h5);
    exp_q.push_back(16'h0001);
    alu1_sel_id = 2'd0;
    next_cycle();                        // T+1
    set_cmd(0, 4'h0); set_data(0, 32'h3);
    sample();
    checks++;
    if (hold_prio_req !== '0) begin
      errors++; $display("FAIL single_early: got %h want 0", hold_prio_req);
    end
    next_cycle();                        // T+2
    set_data(0, 32'hDEAD_BEEF);
    sample();
    exp_v = exp_q.pop_front();
    checks++;
    if (hold_prio_req !== exp_v) begin
      errors++; $display("FAIL single_pulse: got %h want %h", hold_prio_req, exp_v);
    end
    checks++;
    if (alu1_data1 !== 32'h5 || alu1_data2 !== 32'h3) begin
      errors++; $display("FAIL single_ops: got %h %h want 5 3", alu1_data1, alu1_data2);
    end
    for (int i = 0; i < 4; i++) begin    // T+3..T+6: WAIT, no pulse
      next_cycle();
      sample();
      checks++;
      if (hold_prio_req !== '0 || port_busy !== 4'b0001) begin
        errors++; $display("FAIL single_wait: hold=%h busy=%b want 0 0001", hold_prio_req, port_busy);
      end
    end
    next_cycle();
    resp_done = 4'b0001;
    sample();
    checks++;
    if (port_busy !== 4'b0001 || alu1_data1 !== 32'h5 || alu1_data2 !== 32'h3) begin
      errors++; $display("FAIL single_resp_cycle: busy=%b ops=%h %h want 0001 5 3",
                         port_busy, alu1_data1, alu1_data2);
    end
    next_cycle();
    resp_done = '0;
    sample();
    checks++;
    if (port_busy !== 4'b0000) begin
      errors++; $display("FAIL single_release: busy=%b want 0000", port_busy);
    end
  endtask

  task automatic test_all_ports();
    logic [DW-1:0] a1 [NP];
    logic [DW-1:0] a2 [NP];
    logic [CW-1:0] cmds [NP];
    cmds[0] = 4'h1; cmds[1] = 4'h2; cmds[2] = 4'h5; cmds[3] = 4'h6;
    for (int p = 0; p < NP; p++) begin
      a1[p] = DW'($urandom_range(1, 32'h7FFF_FFFF));
      a2[p] = DW'($urandom_range(1, 32'h7FFF_FFFF));
    end
    next_cycle();
    for (int p = 0; p < NP; p++) begin set_cmd(p, cmds[p]); set_data(p, a1[p]); end
    exp_q.push_back(16'h6521);
    next_cycle();
    req_cmd_in = '0;
    for (int p = 0; p < NP; p++) set_data(p, a2[p]);
    next_cycle();
    req_data_in = '0;
    alu1_sel_id = 2'd3;
    alu2_sel_id = 2'd2;
    sample();
    exp_v = exp_q.pop_front();
    checks++;
    if (hold_prio_req !== exp_v || port_busy !== 4'b1111) begin
      errors++; $display("FAIL all_pulse: hold=%h busy=%b want %h 1111", hold_prio_req, port_busy, exp_v);
    end
    checks++;
    if (alu2_data1 !== a1[2] || alu2_data2 !== a2[2]) begin
      errors++; $display("FAIL all_alu2: got %h %h want %h %h", alu2_data1, alu2_data2, a1[2], a2[2]);
    end
    checks++;
    if (alu1_data1 !== a1[3] || alu1_data2 !== a2[3]) begin
      errors++; $display("FAIL all_alu1: got %h %h want %h %h", alu1_data1, alu1_data2, a1[3], a2[3]);
    end
    alu1_sel_id = 2'd2;
    #1;
    checks++;
    if (alu1_data1 !== a1[2] || alu1_data2 !== a2[2]) begin
      errors++; $display("FAIL all_same_id: got %h %h want %h %h", alu1_data1, alu1_data2, a1[2], a2[2]);
    end
    next_cycle();
    resp_done = 4'b1111;
    next_cycle();
    resp_done = '0;
    sample();
    checks++;
    if (port_busy !== 4'b0000 || proto_err !== 4'b0000) begin
      errors++; $display("FAIL all_release: busy=%b err=%b want 0000 0000", port_busy, proto_err);
    end
  endtask

  task automatic test_proto_err();
    next_cycle();
    set_cmd(1, 4'h2); set_data(1, 32'hAA);
    exp_q.push_back(16'h0020);
    alu1_sel_id = 2'd1;
    next_cycle();
    set_cmd(1, 4'h0); set_data(1, 32'hBB);
    next_cycle();
    set_data(1, 32'h0);
    sample();
    exp_v = exp_q.pop_front();
    checks++;
    if (hold_prio_req !== exp_v) begin
      errors++; $display("FAIL proto_first_pulse: got %h want %h", hold_prio_req, exp_v);
    end
    next_cycle();                        // WAIT
    next_cycle();
    set_cmd(1, 4'h2); set_data(1, 32'hCC);
    next_cycle();
    set_cmd(1, 4'h0); set_data(1, 32'hDD);
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++;
      if (hold_prio_req !== '0 || proto_err !== 4'b0010 || port_busy !== 4'b0010) begin
        errors++; $display("FAIL proto_drop: hold=%h err=%b busy=%b want 0 0010 0010",
                           hold_prio_req, proto_err, port_busy);
      end
      checks++;
      if (alu1_data1 !== 32'hAA || alu1_data2 !== 32'hBB) begin
        errors++; $display("FAIL proto_ops: got %h %h want aa bb", alu1_data1, alu1_data2);
      end
      next_cycle();
    end
    req_data_in = '0;
    resp_done = 4'b0010;
    next_cycle();
    resp_done = '0;
    sample();
    checks++;
    if (port_busy !== 4'b0000 || proto_err !== 4'b0010) begin
      errors++; $display("FAIL proto_sticky: busy=%b err=%b want 0000 0010", port_busy, proto_err);
    end
  endtask

  task automatic test_ignored_resp();
    alu2_sel_id = 2'd3;
    next_cycle();                        // T: beat 0
    set_cmd(3, 4'h5); set_data(3, 32'h7);
    exp_q.push_back(16'h5000);
    next_cycle();                        // T+1: CAP2, stray resp_done
    set_cmd(3, 4'h0); set_data(3, 32'h8);
    resp_done = 4'b1000;
    next_cycle();                        // T+2: ISSUE, stray resp_done
    set_data(3, 32'h0);
    sample();
    exp_v = exp_q.pop_front();
    checks++;
    if (hold_prio_req !== exp_v) begin
      errors++; $display("FAIL ign_pulse: got %h want %h", hold_prio_req, exp_v);
    end
    next_cycle();
    resp_done = '0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (port_busy !== 4'b1000) begin
        errors++; $display("FAIL ign_still_wait: busy=%b want 1000", port_busy);
      end
      next_cycle();
    end
    resp_done = 4'b1000;                 // cycle R: honoured in WAIT
    next_cycle();                        // R+1: idle, new beat 0
    resp_done = '0;
    set_cmd(3, 4'h4); set_data(3, 32'h9);
    exp_q.push_back(16'h4000);
    sample();
    checks++;
    if (port_busy !== 4'b0000) begin
      errors++; $display("FAIL ign_release: busy=%b want 0000", port_busy);
    end
    next_cycle();                        // R+2
    set_cmd(3, 4'h0); set_data(3, 32'hA);
    sample();
    checks++;
    if (hold_prio_req !== '0 || port_busy !== 4'b1000) begin
      errors++; $display("FAIL ign_reaccept: hold=%h busy=%b want 0 1000", hold_prio_req, port_busy);
    end
    next_cycle();                        // R+3
    set_data(3, 32'h0);
    sample();
    exp_v = exp_q.pop_front();
    checks++;
    if (hold_prio_req !== exp_v || alu2_data1 !== 32'h9 || alu2_data2 !== 32'hA) begin
      errors++; $display("FAIL ign_second: hold=%h ops=%h %h want %h 9 a",
                         hold_prio_req, alu2_data1, alu2_data2, exp_v);
    end
    checks++;
    if (proto_err !== 4'b0010) begin
      errors++; $display("FAIL ign_err: got %b want 0010", proto_err);
    end
    next_cycle();
    resp_done = 4'b1000;
    next_cycle();
    resp_done = '0;
  endtask

  task automatic test_reset_mid();
    alu1_sel_id = 2'd0;
    alu2_sel_id = 2'd2;
    next_cycle();
    set_cmd(0, 4'h3); set_data(0, 32'h11);
    set_cmd(2, 4'h7); set_data(2, 32'h22);
    exp_q.push_back(16'h0703);
    next_cycle();
    req_cmd_in = '0;
    set_data(0, 32'h33); set_data(2, 32'h44);
    next_cycle();                        // ISSUE cycle: assert reset
    req_data_in = '0;
    reset = 1'b1;
    sample();
    exp_v = exp_q.pop_front();
    checks++;
    if (hold_prio_req !== exp_v) begin
      errors++; $display("FAIL rst_pre_pulse: got %h want %h", hold_prio_req, exp_v);
    end
    next_cycle();
    reset = 1'b0;
    sample();
    checks++;
    if (hold_prio_req !== '0 || port_busy !== '0 || proto_err !== '0) begin
      errors++; $display("FAIL rst_mid_flags: hold=%h busy=%b err=%b want 0",
                         hold_prio_req, port_busy, proto_err);
    end
    checks++;
    if ({alu1_data1, alu1_data2, alu2_data1, alu2_data2} !== '0) begin
      errors++; $display("FAIL rst_mid_data: got %h %h %h %h want 0",
                         alu1_data1, alu1_data2, alu2_data1, alu2_data2);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      checks++;
      if (hold_prio_req !== '0 || port_busy !== '0) begin
        errors++; $display("FAIL rst_no_pulse: hold=%h busy=%b want 0", hold_prio_req, port_busy);
      end
    end
  endtask

`ifdef CMD_HOLD_TIMEOUT_EN
  task automatic test_timeout();
    next_cycle();                        // T
    set_cmd(0, 4'h2); set_data(0, 32'h1);
    next_cycle();
    set_cmd(0, 4'h0); set_data(0, 32'h2);
    next_cycle();                        // T+2 ISSUE
    set_data(0, 32'h0);
    for (int i = 0; i < 10; i++) begin   // W .. W+9
      next_cycle();
      sample();
      checks++;
      if (timeout_err !== '0 || port_busy !== 4'b0001) begin
        errors++; $display("FAIL to_wait: cyc=%0d terr=%b busy=%b want 0 0001", i, timeout_err, port_busy);
      end
    end
    next_cycle();                        // W+10
    sample();
    checks++;
    if (timeout_err !== 4'b0001 || port_busy !== 4'b0000) begin
      errors++; $display("FAIL to_fire: terr=%b busy=%b want 0001 0000", timeout_err, port_busy);
    end
    next_cycle();
    sample();
    checks++;
    if (timeout_err !== '0) begin
      errors++; $display("FAIL to_pulse_len: terr=%b want 0", timeout_err);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset       = 1'b1;
    alu1_sel_id = '0;
    alu2_sel_id = '0;
    clear_inputs();
    test_reset();
    test_single();
    test_all_ports();
    test_proto_err();
    test_ignored_resp();
    test_reset_mid();
`ifdef CMD_HOLD_TIMEOUT_EN
    do_reset();
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
